// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcodes, FSM states and
// the EX/MEM pipeline record.
package execute_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 13;
  localparam int unsigned REG_W  = 3;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluAnd   = 4'd2,
    AluOr    = 4'd3,
    AluXor   = 4'd4,
    AluSll   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluSlt   = 4'd8,
    AluPassB = 4'd9,
    AluMul   = 4'd10
  } alu_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } ex_state_e;

  // Fields that ride alongside the instruction untouched by the ALU.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wb_reg;
    logic              mem_write;
    logic              mem_read;
    logic              reg_write;
  } pass_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_res;
    pass_t             fields;
  } ex_mem_t;

endpackage

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles per
// operation, low DATA_W bits of the product presented alongside done.
module execute_stage_mul_iter
  import execute_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastCount = CntW'(DATA_W - 1);

  logic [DATA_W-1:0] a_q, b_q, acc_q;
  logic [DATA_W-1:0] acc_next;
  logic [CntW-1:0]   count_q;
  logic              busy_q;

  always_comb begin
    acc_next = b_q[0] ? acc_q + a_q : acc_q;
  end

  assign busy   = busy_q;
  assign done   = busy_q && (count_q == LastCount);
  // Final step is folded in so the product is ready on the same edge as done.
  assign result = acc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (flush) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      a_q     <= op_a;
      b_q     <= op_b;
      acc_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q   <= acc_next;
      a_q     <= a_q << 1;
      b_q     <= b_q >> 1;
      count_q <= count_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage with EX/MEM pipeline register: single-cycle ALU plus an iterative
// multiply that stalls decode until its result is committed.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              In_Valid,
  input  logic [PC_W-1:0]   PC,
  input  logic [3:0]        ALUOp,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  input  logic [DATA_W-1:0] WriteDataIn,
  input  logic [REG_W-1:0]  WBReg_In,
  input  logic              Mem_Write_In,
  input  logic              Mem_Read_In,
  input  logic              Reg_Write_In,
  output logic              Stall,
  output logic              Valid_Out,
  output logic [PC_W-1:0]   PCOut,
  output logic [DATA_W-1:0] ALURes,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic [REG_W-1:0]  WBReg_Out,
  output logic              Mem_Write_Out,
  output logic              Mem_Read_Out,
  output logic              Reg_Write_Out
);

  ex_state_e         state_q, state_d;
  ex_mem_t           ex_mem_q, ex_mem_d;
  pass_t             pass_in, pass_q;
  logic [DATA_W-1:0] alu_res;
  logic [4:0]        shamt;
  logic              is_mul;
  logic              mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_result;

  assign shamt  = OpB[4:0];
  assign is_mul = (alu_op_e'(ALUOp) == AluMul);

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(ALUOp))
      AluAdd:   alu_res = OpA + OpB;
      AluSub:   alu_res = OpA - OpB;
      AluAnd:   alu_res = OpA & OpB;
      AluOr:    alu_res = OpA | OpB;
      AluXor:   alu_res = OpA ^ OpB;
      AluSll:   alu_res = OpA << shamt;
      AluSrl:   alu_res = OpA >> shamt;
      AluSra:   alu_res = $unsigned($signed(OpA) >>> shamt);
      AluSlt:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(OpA) < $signed(OpB))};
      AluPassB: alu_res = OpB;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    pass_in.pc        = PC;
    pass_in.wdata     = WriteDataIn;
    pass_in.wb_reg    = WBReg_In;
    pass_in.mem_write = Mem_Write_In;
    pass_in.mem_read  = Mem_Read_In;
    pass_in.reg_write = Reg_Write_In;
  end

  // Default every cycle is a bubble; only a completed instruction overrides it.
  always_comb begin
    state_d   = state_q;
    ex_mem_d  = '0;
    mul_start = 1'b0;
    Stall     = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (In_Valid) begin
            if (is_mul) begin
              mul_start = 1'b1;
              Stall     = 1'b1;
              state_d   = StBusy;
            end else begin
              ex_mem_d.valid   = 1'b1;
              ex_mem_d.alu_res = alu_res;
              ex_mem_d.fields  = pass_in;
            end
          end
        end
        StBusy: begin
          Stall = mul_busy && !mul_done;
          if (mul_done) begin
            ex_mem_d.valid   = 1'b1;
            ex_mem_d.alu_res = mul_result;
            ex_mem_d.fields  = pass_q;
            state_d          = StIdle;
          end else if (!mul_busy) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ex_mem_q <= '0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      ex_mem_q <= ex_mem_d;
      if (mul_start) begin
        pass_q <= pass_in;
      end
    end
  end

  execute_stage_mul_iter u_mul_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .flush  (flush),
    .op_a   (OpA),
    .op_b   (OpB),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_result)
  );

  assign Valid_Out     = ex_mem_q.valid;
  assign ALURes        = ex_mem_q.alu_res;
  assign PCOut         = ex_mem_q.fields.pc;
  assign WriteDataOut  = ex_mem_q.fields.wdata;
  assign WBReg_Out     = ex_mem_q.fields.wb_reg;
  assign Mem_Write_Out = ex_mem_q.fields.mem_write;
  assign Mem_Read_Out  = ex_mem_q.fields.mem_read;
  assign Reg_Write_Out = ex_mem_q.fields.reg_write;

endmodule
